mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Controller in front of a single coreir_mem instance (one write port, one read port).
- Clears the memory after reset, then shares the read port between two read requesters with round-robin arbitration.
- Forwards a single writer to the write port.
- Returns read data with a fixed 1-cycle latency and a requester tag, independent of the memory's sync_read setting.

Parameters:
- width, 5, data width; must match the attached memory.
- depth, 4, number of entries; power of two, ≥2. AW = $clog2(depth).
- sync_read, 1'b0, set equal to the attached memory's sync_read.
- clear_on_reset, 1'b1, 1: write fill to every entry after reset; 0: skip the clear.
- fill, 0, width-bit value written during the clear.

Ports:
- clk  in  1  clock; all state on posedge.
- arst  in  1  asynchronous, active-high reset.
- r0_valid  in  1  requester 0 read request.
- r0_addr  in  AW  requester 0 read address.
- r0_ready  out  1  requester 0 accept.
- r1_valid  in  1  requester 1 read request.
- r1_addr  in  AW  requester 1 read address.
- r1_ready  out  1  requester 1 accept.
- wr_valid  in  1  write request.
- wr_addr  in  AW  write address.
- wr_data  in  width  write data.
- wr_ready  out  1  write accept.
- rsp_valid  out  1  read response valid (1-cycle pulse).
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  width  read data.
- init_done  out  1  clear complete; requests now served.
- mem_raddr  out  AW  to memory raddr.
- mem_rdata  in  width  from memory rdata.
- mem_waddr  out  AW  to memory waddr.
- mem_wdata  out  width  to memory wdata.
- mem_wen  out  1  to memory wen.

Behaviour:
- Reset values: state=INIT (RUN if clear_on_reset=0), init counter=0, prio=0, rsp_valid=0, rsp_id=0, rsp_data register=0 (sync_read=0), init_done=0.
- mem_wen is forced 0 combinationally while arst=1.
- States:
  - INIT:
    - mem_wen=1, mem_waddr=cnt, mem_wdata=fill.
    - cnt increments each cycle.
    - At cnt==depth-1 the write completes and state goes to RUN, so INIT lasts exactly depth cycles.
    - All ready outputs are 0.
  - RUN: init_done=1; this is a terminal state until the next reset.
- Reset asserted mid-INIT restarts the clear from cnt=0 after deassertion.
- Read arbitration (RUN only, combinational readies):
  - r0_ready = run & (!r1_valid | prio==0).
  - r1_ready = run & (!r0_valid | prio==1).
  - Readies do not depend on the requester's own valid.
  - Accept = valid & ready; at most one read is accepted per cycle.
  - After accepting requester i, prio <= ~i. With no accept, prio holds.
  - mem_raddr = r1_addr when r1 is accepted, else r0_addr.
- Response:
  - rsp_valid and rsp_id are registered from the accept, so they appear exactly 1 cycle after accept.
  - sync_read=0: rsp_data is a register loaded from mem_rdata on the accept cycle.
  - sync_read=1: rsp_data = mem_rdata combinationally (the memory supplies the register stage).
  - No response backpressure; rsp_data is meaningful only while rsp_valid=1.
  - Back-to-back accepts give back-to-back responses.
- Write:
  - wr_ready = run.
  - In RUN: mem_wen = wr_valid & ~arst, mem_waddr = wr_addr, mem_wdata = wr_data.
  - The write takes effect at the clock edge that ends the accept cycle.
- Same-cycle read and write to the same address: the read returns the OLD contents (read-before-write). A later read returns the new value.
- Requests presented during INIT stall: ready=0, no response, no write.

Test Plan:
- Clear sequence (width=5, depth=4, fill=5'd7):
  - Release arst → mem_wen=1 for exactly 4 cycles with mem_waddr 0,1,2,3 and mem_wdata 7.
  - init_done rises the next cycle; r0_ready=0 throughout INIT.
  - Reads of addresses 0–3 then return 7.
- Single read: memory preloaded {3:11, 2:21, 1:0, 0:5}; r0_valid=1, r0_addr=2 for one cycle → next cycle rsp_valid=1, rsp_id=0, rsp_data=21. Run with both sync_read=0 and sync_read=1.
- Contention: r0 and r1 both valid for 4 cycles, r0_addr=0, r1_addr=3 → grants r0,r1,r0,r1; responses (id,data) = (0,5),(1,11),(0,5),(1,11) on consecutive cycles.
- Read/write collision: addr 1 holds 0; same cycle wr_valid=1, wr_addr=1, wr_data=9 and r1_valid=1, r1_addr=1 → response 0; a follow-up read of addr 1 → 9.
- Reset mid-clear: assert arst at cnt=2 → outputs return to reset values immediately and mem_wen=0. After release, the clear restarts at address 0 and runs 4 full cycles.
- clear_on_reset=0: init_done=1 and r0_ready=1 on the first cycle after reset release; no INIT writes.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Front end for a single coreir_mem: clears the array after reset, then
// serves a writer and two round-robin readers with a fixed 1-cycle read latency.
module mem_access_ctrl #(
   parameter int                 width          = 5,
   parameter int                 depth          = 4,
   parameter logic               sync_read      = 1'b0,
   parameter logic               clear_on_reset = 1'b1,
   parameter logic [width-1:0]   fill           = '0,
   localparam int                AW             = $clog2(depth)
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             r0_valid,
   input  logic [AW-1:0]    r0_addr,
   output logic             r0_ready,
   input  logic             r1_valid,
   input  logic [AW-1:0]    r1_addr,
   output logic             r1_ready,
   input  logic             wr_valid,
   input  logic [AW-1:0]    wr_addr,
   input  logic [width-1:0] wr_data,
   output logic             wr_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [width-1:0] rsp_data,
   output logic             init_done,
   output logic [AW-1:0]    mem_raddr,
   input  logic [width-1:0] mem_rdata,
   output logic [AW-1:0]    mem_waddr,
   output logic [width-1:0] mem_wdata,
   output logic             mem_wen
);

   typedef enum logic {INIT, RUN} state_t;

   localparam state_t        RST_STATE = clear_on_reset ? INIT : RUN;
   localparam logic [AW-1:0] LAST      = AW'(depth - 1);

   state_t        state;
   state_t        state_n;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_n;
   logic          prio;
   logic          run;
   logic          acc0;
   logic          acc1;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state <= RST_STATE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      mem_wen   = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      unique case (state)
         INIT: begin
            mem_wen   = ~arst;
            mem_waddr = cnt;
            mem_wdata = fill;
            cnt_n     = cnt + AW'(1);
            if (cnt == LAST)
               state_n = RUN;
         end
         RUN: begin
            mem_wen = wr_valid & ~arst;
         end
         default: ;
      endcase
   end

   // Gate with arst so nothing is offered while reset is held.
   assign run       = (state == RUN) & ~arst;
   assign init_done = run;
   assign wr_ready  = run;

   // When both readers contend, prio names the one whose turn it is.
   assign r0_ready  = run & (~r1_valid | ~prio);
   assign r1_ready  = run & (~r0_valid | prio);
   assign acc0      = r0_valid & r0_ready;
   assign acc1      = r1_valid & r1_ready;
   assign mem_raddr = acc1 ? r1_addr : r0_addr;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         prio      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
      end else begin
         rsp_valid <= acc0 | acc1;
         if (acc0 | acc1) begin
            prio   <= acc0;
            rsp_id <= acc1;
         end
      end
   end

   generate
      if (sync_read) begin : g_sync
         assign rsp_data = mem_rdata;
      end else begin : g_async
         logic [width-1:0] rsp_q;

         always_ff @(posedge clk or posedge arst) begin
            if (arst)
               rsp_q <= '0;
            else if (acc0 | acc1)
               rsp_q <= mem_rdata;
         end

         assign rsp_data = rsp_q;
      end
   endgenerate

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: async- and sync-read instances with memory models,
// plus a no-clear instance; directed table, multi-cycle sequences, random run.
module tb_mem_access_ctrl;

   logic       clk = 1'b0;
   logic       arst = 1'b1;
   logic       arst_c = 1'b1;
   logic       r0_valid = 1'b0;
   logic [1:0] r0_addr = '0;
   logic       r1_valid = 1'b0;
   logic [1:0] r1_addr = '0;
   logic       wr_valid = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [4:0] wr_data = '0;

   always #5 clk = ~clk;

   // instance a: async-read memory
   logic       a_r0_ready, a_r1_ready, a_wr_ready, a_rsp_valid, a_rsp_id;
   logic [4:0] a_rsp_data, a_mem_rdata, a_mem_wdata;
   logic       a_init_done, a_mem_wen;
   logic [1:0] a_mem_raddr, a_mem_waddr;
   logic [4:0] mem_a [4];

   // instance b: sync-read memory
   logic       b_r0_ready, b_r1_ready, b_wr_ready, b_rsp_valid, b_rsp_id;
   logic [4:0] b_rsp_data, b_mem_rdata, b_mem_wdata;
   logic       b_init_done, b_mem_wen;
   logic [1:0] b_mem_raddr, b_mem_waddr;
   logic [4:0] mem_b [4];

   // instance c: no clear after reset
   logic       c_r0_ready, c_r1_ready, c_wr_ready, c_rsp_valid, c_rsp_id;
   logic [4:0] c_rsp_data, c_mem_wdata;
   logic       c_init_done, c_mem_wen;
   logic [1:0] c_mem_raddr, c_mem_waddr;

   always @(posedge clk)
      if (a_mem_wen) mem_a[a_mem_waddr] <= a_mem_wdata;
   assign a_mem_rdata = mem_a[a_mem_raddr];

   always @(posedge clk) begin
      if (b_mem_wen) mem_b[b_mem_waddr] <= b_mem_wdata;
      b_mem_rdata <= mem_b[b_mem_raddr];
   end

   mem_access_ctrl #(.width(5), .depth(4), .sync_read(1'b0),
                     .clear_on_reset(1'b1), .fill(5'd7)) dut_a (
      .clk(clk), .arst(arst),
      .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(a_r0_ready),
      .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(a_r1_ready),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(a_wr_ready), .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id),
      .rsp_data(a_rsp_data), .init_done(a_init_done),
      .mem_raddr(a_mem_raddr), .mem_rdata(a_mem_rdata),
      .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata), .mem_wen(a_mem_wen));

   mem_access_ctrl #(.width(5), .depth(4), .sync_read(1'b1),
                     .clear_on_reset(1'b1), .fill(5'd7)) dut_b (
      .clk(clk), .arst(arst),
      .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(b_r0_ready),
      .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(b_r1_ready),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(b_wr_ready), .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id),
      .rsp_data(b_rsp_data), .init_done(b_init_done),
      .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
      .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata), .mem_wen(b_mem_wen));

   mem_access_ctrl #(.width(5), .depth(4), .sync_read(1'b0),
                     .clear_on_reset(1'b0), .fill(5'd7)) dut_c (
      .clk(clk), .arst(arst_c),
      .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(c_r0_ready),
      .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(c_r1_ready),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(c_wr_ready), .rsp_valid(c_rsp_valid), .rsp_id(c_rsp_id),
      .rsp_data(c_rsp_data), .init_done(c_init_done),
      .mem_raddr(c_mem_raddr), .mem_rdata(5'd0),
      .mem_waddr(c_mem_waddr), .mem_wdata(c_mem_wdata), .mem_wen(c_mem_wen));

   typedef struct {
      logic       r0v;
      logic [1:0] r0a;
      logic       r1v;
      logic [1:0] r1a;
      logic       wv;
      logic [1:0] wa;
      logic [4:0] wd;
      logic       er0;
      logic       er1;
      logic       erv;
      logic       eid;
      logic [4:0] ed;
   } vec_t;

   vec_t tbl [18];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input logic ev,
                          input logic eid, input logic [4:0] ed);
      chk({tag, " a rsp_valid"}, int'(a_rsp_valid), int'(ev));
      chk({tag, " b rsp_valid"}, int'(b_rsp_valid), int'(ev));
      if (ev) begin
         chk({tag, " a rsp_id"}, int'(a_rsp_id), int'(eid));
         chk({tag, " b rsp_id"}, int'(b_rsp_id), int'(eid));
         chk({tag, " a rsp_data"}, int'(a_rsp_data), int'(ed));
         chk({tag, " b rsp_data"}, int'(b_rsp_data), int'(ed));
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("row%0d", idx);
      r0_valid = v.r0v; r0_addr = v.r0a;
      r1_valid = v.r1v; r1_addr = v.r1a;
      wr_valid = v.wv;  wr_addr = v.wa; wr_data = v.wd;
      #1;
      chk({tag, " a r0_ready"}, int'(a_r0_ready), int'(v.er0));
      chk({tag, " a r1_ready"}, int'(a_r1_ready), int'(v.er1));
      chk({tag, " b r0_ready"}, int'(b_r0_ready), int'(v.er0));
      chk({tag, " b r1_ready"}, int'(b_r1_ready), int'(v.er1));
      @(posedge clk); #1;
      chk_rsp(tag, v.erv, v.eid, v.ed);
   endtask

   // Releases arst (called at posedge+1) and watches the full clear.
   task automatic do_clear(input string tag);
      r0_valid = 1'b1; r0_addr = 2'd1;
      r1_valid = 1'b0;
      wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 5'd3;
      arst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk({tag, " a mem_wen"}, int'(a_mem_wen), 1);
         chk({tag, " a mem_waddr"}, int'(a_mem_waddr), k);
         chk({tag, " a mem_wdata"}, int'(a_mem_wdata), 7);
         chk({tag, " b mem_waddr"}, int'(b_mem_waddr), k);
         chk({tag, " a r0_ready"}, int'(a_r0_ready), 0);
         chk({tag, " a wr_ready"}, int'(a_wr_ready), 0);
         chk({tag, " a init_done"}, int'(a_init_done), 0);
         @(posedge clk); #1;
         chk({tag, " a rsp_valid"}, int'(a_rsp_valid), 0);
         chk({tag, " b rsp_valid"}, int'(b_rsp_valid), 0);
      end
      r0_valid = 1'b0;
      wr_valid = 1'b0;
      #1;
      chk({tag, " a init_done"}, int'(a_init_done), 1);
      chk({tag, " b init_done"}, int'(b_init_done), 1);
      chk({tag, " a mem_wen after"}, int'(a_mem_wen), 0);
   endtask

   logic [4:0] model [4];
   logic       turn;
   logic       ev, eid;
   logic [4:0] ed;
   int         g;

   initial begin
      //        r0v   r0a   r1v   r1a   wv    wa    wd     er0   er1   erv   eid   ed
      tbl[0]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd7};
      tbl[1]  = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 5'd7};
      tbl[2]  = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd7};
      tbl[3]  = '{1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd7};
      tbl[4]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[5]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[6]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 5'd21, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[7]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[8]  = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 5'd21};
      tbl[9]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[10] = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd5};
      tbl[11] = '{1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd5};
      tbl[12] = '{1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd11};
      tbl[13] = '{1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd5};
      tbl[14] = '{1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd11};
      tbl[15] = '{1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 2'd1, 5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 5'd0};
      tbl[16] = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd9};
      tbl[17] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0};

      #1;
      chk("rst a init_done", int'(a_init_done), 0);
      chk("rst a rsp_valid", int'(a_rsp_valid), 0);
      chk("rst a rsp_id", int'(a_rsp_id), 0);
      chk("rst a rsp_data", int'(a_rsp_data), 0);
      chk("rst a mem_wen", int'(a_mem_wen), 0);
      chk("rst a r0_ready", int'(a_r0_ready), 0);
      chk("rst c init_done", int'(c_init_done), 0);
      @(posedge clk); #1;
      do_clear("clear");

      for (int i = 0; i < 18; i++)
         apply(tbl[i], i);

      // reset in the middle of a clear
      arst = 1'b1;
      @(posedge clk); #1;
      arst = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("mid cnt", int'(a_mem_waddr), 2);
      arst = 1'b1;
      #1;
      chk("mid a mem_wen", int'(a_mem_wen), 0);
      chk("mid b mem_wen", int'(b_mem_wen), 0);
      chk("mid a init_done", int'(a_init_done), 0);
      chk("mid a rsp_valid", int'(a_rsp_valid), 0);
      chk("mid a r1_ready", int'(a_r1_ready), 0);
      @(posedge clk); #1;
      do_clear("reclear");

      // random traffic against a plain array + turn model
      for (int j = 0; j < 4; j++) model[j] = 5'd7;
      turn = 1'b0;
      for (int n = 0; n < 400; n++) begin
         r0_valid = 1'($urandom_range(0, 1));
         r0_addr  = 2'($urandom_range(0, 3));
         r1_valid = 1'($urandom_range(0, 1));
         r1_addr  = 2'($urandom_range(0, 3));
         wr_valid = 1'($urandom_range(0, 1));
         wr_addr  = 2'($urandom_range(0, 3));
         wr_data  = 5'($urandom_range(0, 31));
         #1;
         chk("rnd a r0_ready", int'(a_r0_ready), int'(!r1_valid || turn == 1'b0));
         chk("rnd a r1_ready", int'(a_r1_ready), int'(!r0_valid || turn == 1'b1));
         chk("rnd b r0_ready", int'(b_r0_ready), int'(!r1_valid || turn == 1'b0));
         chk("rnd a mem_wen", int'(a_mem_wen), int'(wr_valid));
         if (r0_valid && r1_valid) g = int'(turn);
         else if (r0_valid)        g = 0;
         else if (r1_valid)        g = 1;
         else                      g = -1;
         ev  = (g >= 0);
         eid = (g == 1);
         ed  = (g == 1) ? model[r1_addr] : model[r0_addr];
         if (ev) turn = (g == 0);
         if (wr_valid) model[wr_addr] = wr_data;
         @(posedge clk); #1;
         chk_rsp("rnd", ev, eid, ed);
      end

      // instance without clear
      r0_valid = 1'b0; r1_valid = 1'b0; wr_valid = 1'b0;
      #1;
      chk("noclr rst init_done", int'(c_init_done), 0);
      chk("noclr rst r0_ready", int'(c_r0_ready), 0);
      arst_c = 1'b0;
      @(posedge clk); #1;
      chk("noclr init_done", int'(c_init_done), 1);
      chk("noclr r0_ready", int'(c_r0_ready), 1);
      chk("noclr mem_wen", int'(c_mem_wen), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
